// File: rtl/fifo_stream_out.sv
// Read-side adapter for sfifo: pops words and streams them out
// through a registered two-entry buffer with packet-last marking.
module fifo_stream_out #(
    parameter int W       = 8,
    parameter int PKT_LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fifo_empty,
    output logic         fifo_r,
    input  logic [W-1:0] fifo_r_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last
);

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);

    logic [W-1:0]  b0_q, b0_d;
    logic [W-1:0]  b1_q, b1_d;
    logic [1:0]    occ_q, occ_d;
    logic          rd_pend_q;
    logic [BW-1:0] beat_q, beat_d;
    logic          deq;
    logic [2:0]    fill;
    logic [1:0]    tail;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = b0_q;
    assign m_last  = m_valid && (beat_q == LAST);
    assign deq     = m_valid && m_ready;

    // Entries held once this cycle's arrival and pop have settled.
    assign fill   = {1'b0, occ_q} + {2'b0, rd_pend_q} - {2'b0, deq};
    assign fifo_r = !rst && !fifo_empty && (fill < 3'd2);
    assign occ_d  = fill[1:0];

    always_comb begin
        b0_d = b0_q;
        b1_d = b1_q;
        tail = occ_q;
        if (deq) begin
            b0_d = b1_q;
            tail = occ_q - 2'd1;
        end
        if (rd_pend_q) begin
            if (tail == 2'd0) begin
                b0_d = fifo_r_data;
            end else begin
                b1_d = fifo_r_data;
            end
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (deq) begin
            beat_d = (beat_q == LAST) ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q      <= '0;
            b1_q      <= '0;
            occ_q     <= 2'd0;
            rd_pend_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            occ_q     <= occ_d;
            rd_pend_q <= fifo_r;
            beat_q    <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural sfifo
// on the read side and a deq collector on the stream side.
module tb_fifo_stream_out;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_r;
    logic [7:0] fifo_r_data = 8'h00;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] mem [0:255];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;

    int n_chk  = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    int viol   = 0;
    int cyc    = 0;
    logic [8:0] dq [$];
    int         st [$];

    fifo_stream_out #(.W(8), .PKT_LEN(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_r      (fifo_r),
        .fifo_r_data (fifo_r_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 8'd1;
        end
        if (fifo_r && !fifo_empty) begin
            fifo_r_data <= mem[rp];
            rp          <= rp + 8'd1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_r) rd_cnt <= rd_cnt + 1;
        if (fifo_r && fifo_empty) viol <= viol + 1;
        if (!rst && m_valid && m_ready) begin
            dq.push_back({m_last, m_data});
            st.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_deq(input int target, input int budget);
        int n;
        n = 0;
        while (dq.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("deq_timeout", 32'(dq.size() >= target), 32'd1);
    endtask

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_fifo_r"}, 32'(fifo_r), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_last"}, 32'(m_last), 32'd0);
    endtask

    task automatic chk_seq8(input int b, input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_data"}, 32'(dq[b+i][7:0]), 32'(i));
            chk({tag, "_last"}, 32'(dq[b+i][8]), 32'(i == 3 || i == 7));
            if (i > 0) chk({tag, "_gap"}, 32'(st[b+i] - st[b+i-1]), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int r0;
        logic [7:0] v;

        rst     = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        repeat (2) begin
            @(negedge clk);
            chk_rst_outs("rst");
        end
        rst = 1'b0;
        #1;
        chk("rst_release_fifo_r", 32'(fifo_r), 32'd1);
        m_ready = 1'b1;
        wait_deq(3, 20);
        chk("pre_w0", 32'(dq[0]), 32'h0A1);
        chk("pre_w1", 32'(dq[1]), 32'h0A2);
        chk("pre_w2", 32'(dq[2]), 32'h0A3);
        repeat (3) @(negedge clk);
        chk("idle_valid", 32'(m_valid), 32'd0);

        // single word: beat 3 of the first packet
        r0 = rd_cnt;
        push(8'h5A);
        chk("single_r_n", 32'(fifo_r), 32'd1);
        chk("single_v_n", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("single_r_n1", 32'(fifo_r), 32'd0);
        chk("single_v_n1", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("single_v_n2", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'h5A);
        chk("single_last", 32'(m_last), 32'd1);
        @(negedge clk);
        chk("single_v_n3", 32'(m_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("single_pulses", 32'(rd_cnt - r0), 32'd1);

        b = dq.size();
        for (int i = 0; i < 8; i++) push(8'(i));
        wait_deq(b + 8, 40);
        chk_seq8(b, "stream");
        repeat (3) @(negedge clk);

        m_ready = 1'b0;
        r0 = rd_cnt;
        b = dq.size();
        for (int i = 0; i < 8; i++) push(8'(i));
        repeat (6) begin
            @(negedge clk);
            chk("bp_valid", 32'(m_valid), 32'd1);
            chk("bp_hold", 32'(m_data), 32'd0);
        end
        chk("bp_pulses", 32'(rd_cnt - r0), 32'd2);
        chk("bp_no_deq", 32'(dq.size()), 32'(b));
        m_ready = 1'b1;
        wait_deq(b + 8, 40);
        chk_seq8(b, "bp");
        repeat (3) @(negedge clk);

        b = dq.size();
        for (int i = 0; i < 40; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            push(8'(i * 7 + 3));
        end
        for (int n = 0; n < 400 && dq.size() < b + 40; n++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        m_ready = 1'b1;
        wait_deq(b + 40, 20);
        for (int i = 0; i < 40; i++) begin
            v = 8'(i * 7 + 3);
            chk("rand_order", 32'(dq[b+i][7:0]), 32'(v));
        end
        chk("rand_no_empty_read", 32'(viol), 32'd0);
        repeat (3) @(negedge clk);

        m_ready = 1'b0;
        b = dq.size();
        for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
        m_ready = 1'b1;
        wait_deq(b + 2, 10);
        chk("mid_w0", 32'(dq[b]), 32'h010);
        chk("mid_w1", 32'(dq[b+1]), 32'h011);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_rst_outs("mid_rst");
        end
        b = dq.size();
        chk("mid_rst_no_deq", 32'(b), 32'(dq.size()));
        rst = 1'b0;
        wait_deq(b + 4, 20);
        chk("mid_after0", 32'(dq[b]), 32'h014);
        chk("mid_after1", 32'(dq[b+1]), 32'h015);
        chk("mid_after2", 32'(dq[b+2]), 32'h016);
        chk("mid_after3", 32'(dq[b+3]), 32'h117);
        repeat (8) @(negedge clk);
        chk("final_no_empty_read", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
